data_uncache_resp: RTL and testbench
====================================

# data_uncache_resp

Responder side of the pipeline data-access interface. It accepts load/store requests issued by the execute stage and samples the physical address, cancel and uncache attributes driven by the memory stage one cycle later. It performs each access as a single-beat transaction on the uncached data bus and returns `data_data_ok`/`data_rdata` to the memory stage. Requests are blocking, one at a time, with an optional store buffer.

## Interface
Parameters:
- `WBUF_DEPTH`, default 2: store-buffer entries, power of two, ≥2. Used only when `DATA_RESP_WBUF_EN` is defined.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `data_req` in 1: request valid (execute stage).
- `data_wr` in 1: 1 = store, 0 = load.
- `data_size` in 2: 0 = byte, 1 = half, 2 = word.
- `data_wstrb` in 4: store byte enables.
- `data_wdata` in 32: store data.
- `data_addr_ok` out 1: request accepted when `data_req & data_addr_ok`.
- `data_paddr` in 32: physical address, valid in LOOKUP.
- `data_uncache_en` in 1: uncached attribute, valid in LOOKUP. Sampled for the bus attribute only.
- `tlb_excp_cancel_req` in 1: valid in LOOKUP. Kills the access.
- `flush` in 1: pipeline flush (excp/ertn/refetch/icacop/idle).
- `data_data_ok` out 1: one-cycle completion pulse.
- `data_rdata` out 32: raw loaded word, valid with `data_data_ok`. Byte/half extraction is done downstream.
- `dcache_miss` out 1: equal to `data_data_ok`; every access counts as a miss.
- `rd_req` out 1, `rd_addr` out 32, `rd_size` out 2, `rd_uncache` out 1: read request. Held until `rd_ready`.
- `rd_ready` in 1: read request accepted.
- `ret_valid` in 1, `ret_data` in 32: read return, single beat.
- `wr_req` out 1, `wr_addr` out 32, `wr_size` out 2, `wr_strb` out 4, `wr_data` out 32: write request. Held until `wr_ready`.
- `wr_ready` in 1: write request accepted.
- `wr_resp` in 1: write response pulse.

## Operation
- Main FSM states: IDLE, LOOKUP, RD_REQ, RD_WAIT, RD_DRAIN, WR_REQ, WR_WAIT, RESP.
- IDLE:
  - `data_addr_ok = 1`.
  - On accept, latch wr/size/wstrb/wdata and go to LOOKUP.
- LOOKUP (exactly one cycle unless stalled):
  - Latch `data_paddr` and `data_uncache_en`.
  - If `tlb_excp_cancel_req | flush`, go to IDLE with no `data_data_ok`. Cancel wins over everything.
  - Otherwise a load goes to RD_REQ and a store goes to WR_REQ. With WBUF, see Configuration.
- RD_REQ:
  - Drive `rd_req`. On `rd_ready`, go to RD_WAIT.
  - A `flush` here (before the handshake) goes straight to IDLE. `rd_req` drops the next cycle.
- RD_WAIT:
  - On `ret_valid`, register `ret_data` into `data_rdata` and go to RESP.
  - A `flush` before `ret_valid` goes to RD_DRAIN.
- RD_DRAIN:
  - Wait for `ret_valid`, discard the data, go to IDLE. No `data_data_ok`.
- WR_REQ:
  - Drive `wr_req`. On `wr_ready`, go to WR_WAIT.
  - Flush is ignored: once a store passes LOOKUP it is committed.
- WR_WAIT:
  - On `wr_resp`, go to RESP.
- RESP:
  - `data_data_ok = dcache_miss = 1` for one cycle, then IDLE.
  - If `flush` is high in RESP, the pulse is suppressed.
- `data_rdata` holds its last value until the next load completes. It is 0 after reset.
- Bus attributes:
  - `rd_size`/`wr_size` are `data_size`.
  - `rd_addr`/`wr_addr` are the latched `data_paddr` (unaligned, unmodified).
  - `rd_uncache` is the latched `data_uncache_en`.

## Timing
- Reset values:
  - FSM in IDLE.
  - `data_addr_ok` = 1.
  - All other outputs 0: `data_data_ok`, `dcache_miss`, `data_rdata`, `rd_req`, `wr_req`, and all address/size/strb/data/`rd_uncache` outputs.
  - Store buffer empty.
- Reset mid-transaction returns to IDLE immediately. Bus handshakes are abandoned; the bus is reset in the same cycle.
- Load with zero-wait bus (`rd_ready` in RD_REQ, `ret_valid` in the first RD_WAIT cycle): accept at T, LOOKUP at T+1, `rd_req` at T+2, RD_WAIT at T+3, `data_data_ok` at T+4.
- Store without WBUF, with zero-wait bus (`wr_ready` in the first WR_REQ cycle, `wr_resp` in the first WR_WAIT cycle): `wr_req` at T+2, WR_WAIT at T+3, `data_data_ok` at T+4.
- `data_addr_ok` is high only in IDLE. The earliest next accept is the cycle after RESP, or the cycle after LOOKUP on cancel.
- `rd_req` and `wr_req` are never high in the same cycle.

## Configuration
- `DATA_RESP_WBUF_EN`:
  - Defined:
    - A non-cancelled store in LOOKUP pushes {paddr, size, strb, wdata} into a FIFO of `WBUF_DEPTH` entries and goes to RESP (`data_data_ok` at T+2).
    - If the FIFO is full, the FSM stays in LOOKUP and re-evaluates cancel/flush each cycle until space frees.
    - A separate drain FSM (W_IDLE → W_REQ → W_WAIT) issues FIFO entries in order over the wr_* port, popping on `wr_resp`.
    - A load leaving LOOKUP stalls in RD_REQ (with `rd_req` = 0) until the FIFO is empty and the drain FSM is idle.
    - Push and pop in the same cycle keep the count unchanged.
    - Read/write pointers wrap modulo `WBUF_DEPTH`.
  - Undefined: no FIFO; stores use WR_REQ/WR_WAIT as described in Operation.

## Test plan
- Load: paddr 0x1C00_0104, `ret_data` 0xDEAD_BEEF, zero-wait bus → `rd_addr` 0x1C00_0104, `data_data_ok` = `dcache_miss` = 1 at T+4, `data_rdata` 0xDEAD_BEEF.
- `tlb_excp_cancel_req` = 1 in LOOKUP → no `rd_req`, no `data_data_ok`, `data_addr_ok` = 1 at T+2.
- Flush in RD_WAIT, then `ret_valid` 3 cycles later → no `data_data_ok`; the next load's data is not corrupted by the stale return.
- Store with strb 0b0011, wdata 0x0000_1234, `wr_resp` delayed 5 cycles (no WBUF) → `data_data_ok` exactly once, the cycle after `wr_resp`.
- WBUF, depth 2, `wr_ready` held 0: three stores → the third stalls in LOOKUP. A following load's `rd_req` appears only after both writes receive `wr_resp`.
- Reset asserted in WR_WAIT → all outputs at reset values the next cycle; a new request is accepted right after reset deasserts.

Source files
------------

// File: rtl/data_uncache_resp.sv
// Uncached data-access responder: one blocking load/store at a time, each issued as a single-beat bus transaction.
// Optional store buffer enabled by defining DATA_RESP_WBUF_EN (depth WBUF_DEPTH).
module data_uncache_resp #(
  parameter int WBUF_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          data_req,
  input  logic                          data_wr,
  input  logic [1:0]                    data_size,
  input  logic [3:0]                    data_wstrb,
  input  logic [31:0]                   data_wdata,
  output logic                          data_addr_ok,
  input  logic [31:0]                   data_paddr,
  input  logic                          data_uncache_en,
  input  logic                          tlb_excp_cancel_req,
  input  logic                          flush,
  output logic                          data_data_ok,
  output logic [31:0]                   data_rdata,
  output logic                          dcache_miss,
  output logic                          rd_req,
  output logic [31:0]                   rd_addr,
  output logic [1:0]                    rd_size,
  output logic                          rd_uncache,
  input  logic                          rd_ready,
  input  logic                          ret_valid,
  input  logic [31:0]                   ret_data,
  output logic                          wr_req,
  output logic [31:0]                   wr_addr,
  output logic [1:0]                    wr_size,
  output logic [3:0]                    wr_strb,
  output logic [31:0]                   wr_data,
  input  logic                          wr_ready,
  input  logic                          wr_resp,
  output logic [2:0]                    dbg_state,
  output logic [$clog2(WBUF_DEPTH):0]   dbg_wbuf_cnt
);

  // Handshakes: a bus request is held until its ready is seen high in the same cycle;
  // ret_valid and wr_resp are single-cycle pulses that are consumed when they arrive.
  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_RD_REQ, S_RD_WAIT, S_RD_DRAIN, S_WR_REQ, S_WR_WAIT, S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] paddr_q, paddr_d;
  logic        unc_q, unc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wbuf_idle;

`ifdef DATA_RESP_WBUF_EN
  localparam int unsigned AW = $clog2(WBUF_DEPTH);
  logic wbuf_push, wbuf_full;
`endif

  assign rd_req = (state_q == S_RD_REQ) && wbuf_idle;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    paddr_d = paddr_q;
    unc_d   = unc_q;
    rdata_d = rdata_q;
`ifdef DATA_RESP_WBUF_EN
    wbuf_push = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (data_req) begin
          wr_d    = data_wr;
          size_d  = data_size;
          wstrb_d = data_wstrb;
          wdata_d = data_wdata;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        paddr_d = data_paddr;
        unc_d   = data_uncache_en;
        if (tlb_excp_cancel_req || flush) state_d = S_IDLE;
        else if (!wr_q)                   state_d = S_RD_REQ;
`ifdef DATA_RESP_WBUF_EN
        else if (!wbuf_full) begin
          wbuf_push = 1'b1;
          state_d   = S_RESP;
        end
`else
        else                              state_d = S_WR_REQ;
`endif
      end
      S_RD_REQ: begin
        // A request already accepted by the bus must still have its return drained.
        if (rd_req && rd_ready) state_d = flush ? S_RD_DRAIN : S_RD_WAIT;
        else if (flush)         state_d = S_IDLE;
      end
      S_RD_WAIT: begin
        if (ret_valid) begin
          if (flush) state_d = S_IDLE;
          else begin
            rdata_d = ret_data;
            state_d = S_RESP;
          end
        end else if (flush) begin
          state_d = S_RD_DRAIN;
        end
      end
      S_RD_DRAIN: if (ret_valid) state_d = S_IDLE;
      S_WR_REQ:   if (wr_ready)  state_d = S_WR_WAIT;
      S_WR_WAIT:  if (wr_resp)   state_d = S_RESP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'b0;
      wstrb_q <= 4'b0;
      wdata_q <= 32'b0;
      paddr_q <= 32'b0;
      unc_q   <= 1'b0;
      rdata_q <= 32'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      paddr_q <= paddr_d;
      unc_q   <= unc_d;
      rdata_q <= rdata_d;
    end
  end

  assign data_addr_ok = (state_q == S_IDLE);
  assign data_data_ok = (state_q == S_RESP) && !flush;
  assign dcache_miss  = data_data_ok;
  assign data_rdata   = rdata_q;
  assign rd_addr      = paddr_q;
  assign rd_size      = size_q;
  assign rd_uncache   = unc_q;
  assign dbg_state    = state_q;

`ifdef DATA_RESP_WBUF_EN
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT} wstate_e;

  wstate_e       wstate_q, wstate_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wbuf_pop;
  logic [31:0]   fa_q [WBUF_DEPTH];
  logic [1:0]    fs_q [WBUF_DEPTH];
  logic [3:0]    fb_q [WBUF_DEPTH];
  logic [31:0]   fd_q [WBUF_DEPTH];

  assign wbuf_full = (cnt_q == (AW+1)'(WBUF_DEPTH));
  // Loads wait until every buffered store has been acknowledged, keeping memory order.
  assign wbuf_idle = (cnt_q == '0) && (wstate_q == W_IDLE);

  always_comb begin
    wstate_d = wstate_q;
    wbuf_pop = 1'b0;
    case (wstate_q)
      W_IDLE:  if (cnt_q != '0) wstate_d = W_REQ;
      W_REQ:   if (wr_ready)    wstate_d = W_WAIT;
      W_WAIT: begin
        if (wr_resp) begin
          wbuf_pop = 1'b1;
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    wptr_d = wptr_q + AW'(wbuf_push);
    rptr_d = rptr_q + AW'(wbuf_pop);
    cnt_d  = cnt_q + (AW+1)'(wbuf_push) - (AW+1)'(wbuf_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wstate_q <= W_IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        fa_q[i] <= 32'b0;
        fs_q[i] <= 2'b0;
        fb_q[i] <= 4'b0;
        fd_q[i] <= 32'b0;
      end
    end else begin
      wstate_q <= wstate_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      if (wbuf_push) begin
        fa_q[wptr_q] <= data_paddr;
        fs_q[wptr_q] <= size_q;
        fb_q[wptr_q] <= wstrb_q;
        fd_q[wptr_q] <= wdata_q;
      end
    end
  end

  assign wr_req       = (wstate_q == W_REQ);
  assign wr_addr      = fa_q[rptr_q];
  assign wr_size      = fs_q[rptr_q];
  assign wr_strb      = fb_q[rptr_q];
  assign wr_data      = fd_q[rptr_q];
  assign dbg_wbuf_cnt = cnt_q;
`else
  assign wbuf_idle    = 1'b1;
  assign wr_req       = (state_q == S_WR_REQ);
  assign wr_addr      = paddr_q;
  assign wr_size      = size_q;
  assign wr_strb      = wstrb_q;
  assign wr_data      = wdata_q;
  assign dbg_wbuf_cnt = '0;
`endif

endmodule

// File: tb/tb_data_uncache_resp.sv
// Directed bench for data_uncache_resp: vector table of zero-wait loads/stores plus
// hand-written sequences for cancel, flush, delayed response, reset and the store buffer.
module tb_data_uncache_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic [31:0] data_paddr;
  logic        data_uncache_en, tlb_excp_cancel_req, flush;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        dcache_miss;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [1:0]  rd_size;
  logic        rd_uncache, rd_ready, ret_valid;
  logic [31:0] ret_data;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [1:0]  wr_size;
  logic [3:0]  wr_strb;
  logic [31:0] wr_data;
  logic        wr_ready, wr_resp;
  logic [2:0]  dbg_state;
  logic [1:0]  dbg_wbuf_cnt;

  int n_checks = 0;
  int n_errors = 0;

  data_uncache_resp dut (
    .clk(clk), .reset(reset),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_paddr(data_paddr), .data_uncache_en(data_uncache_en),
    .tlb_excp_cancel_req(tlb_excp_cancel_req), .flush(flush),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .dcache_miss(dcache_miss),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size), .rd_uncache(rd_uncache),
    .rd_ready(rd_ready), .ret_valid(ret_valid), .ret_data(ret_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size), .wr_strb(wr_strb),
    .wr_data(wr_data), .wr_ready(wr_ready), .wr_resp(wr_resp),
    .dbg_state(dbg_state), .dbg_wbuf_cnt(dbg_wbuf_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] paddr;
    logic        unc;
    logic [31:0] ret;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'b0; data_wstrb = 4'b0;
    data_wdata = 32'b0; data_paddr = 32'b0; data_uncache_en = 1'b0;
    tlb_excp_cancel_req = 1'b0; flush = 1'b0;
    rd_ready = 1'b0; ret_valid = 1'b0; ret_data = 32'b0;
    wr_ready = 1'b0; wr_resp = 1'b0;
  endtask

  task automatic check_reset_values();
    chk1("rst_addr_ok", data_addr_ok, 1'b1);
    chk1("rst_data_ok", data_data_ok, 1'b0);
    chk1("rst_miss", dcache_miss, 1'b0);
    chk1("rst_rd_req", rd_req, 1'b0);
    chk1("rst_wr_req", wr_req, 1'b0);
    chk1("rst_rd_uncache", rd_uncache, 1'b0);
    chk32("rst_rdata", data_rdata, 32'h0);
    chk32("rst_rd_addr", rd_addr, 32'h0);
    chk32("rst_rd_size", 32'(rd_size), 32'h0);
    chk32("rst_wr_addr", wr_addr, 32'h0);
    chk32("rst_wr_size", 32'(wr_size), 32'h0);
    chk32("rst_wr_strb", 32'(wr_strb), 32'h0);
    chk32("rst_wr_data", wr_data, 32'h0);
  endtask

  // Driver: one access with a zero-wait bus, checked cycle by cycle from T to T+5.
  task automatic run_vec(input vec_t v, input bit post_reset);
    data_req = 1'b1; data_wr = v.wr; data_size = v.size;
    data_wstrb = v.strb; data_wdata = v.wdata;
    sample();
    if (post_reset) check_reset_values();
    chk1("accept_addr_ok", data_addr_ok, 1'b1);
    next_cycle();
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'b0; data_wstrb = 4'b0; data_wdata = 32'b0;
    data_paddr = v.paddr; data_uncache_en = v.unc;
    sample();
    chk1("lookup_addr_ok", data_addr_ok, 1'b0);
    chk1("lookup_rd_req", rd_req, 1'b0);
    chk1("lookup_wr_req", wr_req, 1'b0);
    next_cycle();
    data_paddr = ~v.paddr; data_uncache_en = ~v.unc;
    if (!v.wr) begin
      rd_ready = 1'b1;
      sample();
      chk1("ld_rd_req", rd_req, 1'b1);
      chk1("ld_wr_req", wr_req, 1'b0);
      chk32("ld_rd_addr", rd_addr, v.paddr);
      chk32("ld_rd_size", 32'(rd_size), 32'(v.size));
      chk1("ld_rd_uncache", rd_uncache, v.unc);
      next_cycle();
      rd_ready = 1'b0; ret_valid = 1'b1; ret_data = v.ret;
      sample();
      chk1("ld_wait_rd_req", rd_req, 1'b0);
      chk1("ld_wait_data_ok", data_data_ok, 1'b0);
      next_cycle();
      ret_valid = 1'b0; ret_data = 32'h0;
    end else begin
      wr_ready = 1'b1;
      sample();
      chk1("st_wr_req", wr_req, 1'b1);
      chk1("st_rd_req", rd_req, 1'b0);
      chk32("st_wr_addr", wr_addr, v.paddr);
      chk32("st_wr_size", 32'(wr_size), 32'(v.size));
      chk32("st_wr_strb", 32'(wr_strb), 32'(v.strb));
      chk32("st_wr_data", wr_data, v.wdata);
      next_cycle();
      wr_ready = 1'b0; wr_resp = 1'b1;
      sample();
      chk1("st_wait_wr_req", wr_req, 1'b0);
      chk1("st_wait_data_ok", data_data_ok, 1'b0);
      next_cycle();
      wr_resp = 1'b0;
    end
    data_paddr = 32'h0; data_uncache_en = 1'b0;
    sample();
    chk1("resp_data_ok", data_data_ok, 1'b1);
    chk1("resp_miss", dcache_miss, 1'b1);
    chk32("resp_rdata", data_rdata, v.exp_rdata);
    next_cycle();
    sample();
    chk1("after_data_ok", data_data_ok, 1'b0);
    chk1("after_addr_ok", data_addr_ok, 1'b1);
    next_cycle();
  endtask

  // Accept a request at T and drive LOOKUP at T+1 without checking; leaves the bench at T+2.
  task automatic issue(input logic wr, input logic [31:0] paddr, input logic [3:0] strb,
                       input logic [31:0] wdata, input logic cancel);
    data_req = 1'b1; data_wr = wr; data_size = 2'd2; data_wstrb = strb; data_wdata = wdata;
    next_cycle();
    data_req = 1'b0; data_paddr = paddr; tlb_excp_cancel_req = cancel;
    sample();
    chk1("issue_lookup_data_ok", data_data_ok, 1'b0);
    next_cycle();
    tlb_excp_cancel_req = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   pulses;
    int   pulse_at;

    vecs[0] = '{1'b0, 2'd2, 4'h0, 32'h0,          32'h1C00_0104, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 2'd2, 4'hF, 32'h1234_5678,  32'h0000_1000, 1'b0, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 2'd0, 4'h0, 32'h0,          32'h1C00_0003, 1'b0, 32'h0000_00A5, 32'h0000_00A5};
    vecs[3] = '{1'b1, 2'd1, 4'h3, 32'h0000_1234,  32'h1C00_0102, 1'b1, 32'h0,         32'h0000_00A5};
    vecs[4] = '{1'b0, 2'd1, 4'h0, 32'h0,          32'h0000_0ABE, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 2'd0, 4'h8, 32'h7700_0000,  32'hFFFF_FFFF, 1'b0, 32'h0,         32'hCAFE_F00D};

    clear_inputs();
    reset = 1'b1;
    repeat (3) next_cycle();
    sample();
    check_reset_values();
    next_cycle();
    reset = 1'b0;
    next_cycle();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b0);

    // Cancel in LOOKUP: no bus request, back in IDLE at T+2.
    issue(1'b0, 32'h1C00_0200, 4'h0, 32'h0, 1'b1);
    sample();
    chk1("cancel_rd_req", rd_req, 1'b0);
    chk1("cancel_addr_ok", data_addr_ok, 1'b1);
    chk1("cancel_data_ok", data_data_ok, 1'b0);
    next_cycle();

    // Flush in RD_WAIT, stale return three cycles later must be discarded.
    issue(1'b0, 32'h0000_2000, 4'h0, 32'h0, 1'b0);
    rd_ready = 1'b1;
    next_cycle();
    rd_ready = 1'b0; flush = 1'b1;
    sample();
    chk1("drain_flush_data_ok", data_data_ok, 1'b0);
    next_cycle();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk1("drain_addr_ok", data_addr_ok, 1'b0);
      chk1("drain_data_ok", data_data_ok, 1'b0);
      next_cycle();
    end
    ret_valid = 1'b1; ret_data = 32'hBAD0_BAD0;
    sample();
    chk1("drain_ret_data_ok", data_data_ok, 1'b0);
    next_cycle();
    ret_valid = 1'b0; ret_data = 32'h0;
    sample();
    chk1("drain_done_addr_ok", data_addr_ok, 1'b1);
    chk1("drain_done_data_ok", data_data_ok, 1'b0);
    chk32("drain_rdata_kept", data_rdata, 32'hCAFE_F00D);
    next_cycle();
    v = '{1'b0, 2'd2, 4'h0, 32'h0, 32'h0000_2004, 1'b0, 32'h600D_600D, 32'h600D_600D};
    run_vec(v, 1'b0);

    // Store: flush in WR_REQ is ignored, wr_resp delayed 5 cycles, exactly one data_ok.
    issue(1'b1, 32'h1C00_0300, 4'h3, 32'h0000_1234, 1'b0);
    flush = 1'b1;
    sample();
    chk1("st_flush_wr_req", wr_req, 1'b1);
    next_cycle();
    flush = 1'b0; wr_ready = 1'b1;
    sample();
    chk1("st_flush_still_wr_req", wr_req, 1'b1);
    chk32("st_delay_strb", 32'(wr_strb), 32'h3);
    chk32("st_delay_data", wr_data, 32'h0000_1234);
    next_cycle();
    wr_ready = 1'b0;
    pulses = 0; pulse_at = -1;
    for (int i = 0; i < 12; i++) begin
      wr_resp = (i == 5);
      sample();
      if (data_data_ok) begin
        pulses++;
        pulse_at = i;
      end
      next_cycle();
      wr_resp = 1'b0;
    end
    chk32("st_delay_pulses", 32'(pulses), 32'd1);
    chk32("st_delay_pulse_cycle", 32'(pulse_at), 32'd6);

    // Flush in RD_REQ before the handshake: request dropped the next cycle.
    issue(1'b0, 32'h0000_3000, 4'h0, 32'h0, 1'b0);
    flush = 1'b1;
    sample();
    chk1("rdreq_flush_rd_req", rd_req, 1'b1);
    next_cycle();
    flush = 1'b0;
    sample();
    chk1("rdreq_flush_dropped", rd_req, 1'b0);
    chk1("rdreq_flush_addr_ok", data_addr_ok, 1'b1);
    next_cycle();

    // Flush in RESP suppresses the completion pulse.
    issue(1'b0, 32'h0000_3004, 4'h0, 32'h0, 1'b0);
    rd_ready = 1'b1;
    next_cycle();
    rd_ready = 1'b0; ret_valid = 1'b1; ret_data = 32'h1111_2222;
    next_cycle();
    ret_valid = 1'b0; flush = 1'b1;
    sample();
    chk1("resp_flush_data_ok", data_data_ok, 1'b0);
    chk1("resp_flush_miss", dcache_miss, 1'b0);
    next_cycle();
    flush = 1'b0;
    sample();
    chk1("resp_flush_addr_ok", data_addr_ok, 1'b1);
    next_cycle();

    // Reset in WR_WAIT, then an immediate new request.
    issue(1'b1, 32'h0000_4000, 4'hF, 32'hAAAA_5555, 1'b0);
    wr_ready = 1'b1;
    next_cycle();
    wr_ready = 1'b0; reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    v = '{1'b0, 2'd2, 4'h0, 32'h0, 32'h0000_4008, 1'b1, 32'h5A5A_A5A5, 32'h5A5A_A5A5};
    run_vec(v, 1'b1);

`ifdef DATA_RESP_WBUF_EN
    begin
      int writes;
      bit resp_pending;
      bit seen;
      // Three stores with wr_ready low: two are buffered, the third stalls in LOOKUP.
      for (int k = 0; k < 3; k++) begin
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hF;
        data_wdata = 32'h1000 + 32'(k);
        next_cycle();
        data_req = 1'b0; data_paddr = 32'h0000_5000 + 32'(4 * k);
        if (k < 2) begin
          sample();
          chk1("wb_push_lookup", data_data_ok, 1'b0);
          next_cycle();
          sample();
          chk1("wb_push_data_ok", data_data_ok, 1'b1);
          next_cycle();
        end else begin
          for (int s = 0; s < 4; s++) begin
            sample();
            chk32("wb_full_stall_state", 32'(dbg_state), 32'd1);
            chk1("wb_full_stall_data_ok", data_data_ok, 1'b0);
            next_cycle();
          end
        end
      end
      writes = 0; resp_pending = 1'b0; seen = 1'b0;
      wr_ready = 1'b1;
      for (int c = 0; c < 30 && !seen; c++) begin
        wr_resp = resp_pending;
        sample();
        if (resp_pending) writes++;
        if (data_data_ok) seen = 1'b1;
        if (wr_req) chk32("wb_drain_order", wr_addr, 32'h0000_5000 + 32'(4 * writes));
        resp_pending = wr_req;
        next_cycle();
      end
      wr_resp = 1'b0;
      chk1("wb_third_store_done", seen, 1'b1);
      data_req = 1'b1; data_wr = 1'b0;
      next_cycle();
      data_req = 1'b0; data_paddr = 32'h0000_6000;
      next_cycle();
      seen = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
        wr_resp = resp_pending;
        sample();
        if (resp_pending) writes++;
        if (rd_req) begin
          seen = 1'b1;
          chk32("wb_load_after_writes", 32'(writes), 32'd3);
          chk1("wb_no_overlap", wr_req, 1'b0);
        end
        if (wr_req) chk32("wb_drain_order", wr_addr, 32'h0000_5000 + 32'(4 * writes));
        resp_pending = wr_req;
        if (!seen) next_cycle();
      end
      wr_resp = 1'b0; wr_ready = 1'b0;
      chk1("wb_load_rd_req_seen", seen, 1'b1);
      rd_ready = 1'b1;
      next_cycle();
      rd_ready = 1'b0; ret_valid = 1'b1; ret_data = 32'h0BAD_F00D;
      next_cycle();
      ret_valid = 1'b0;
      sample();
      chk1("wb_load_data_ok", data_data_ok, 1'b1);
      chk32("wb_load_rdata", data_rdata, 32'h0BAD_F00D);
      next_cycle();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
